ahb_master_arbiter: RTL

- Shares one AHB-Lite slave port (hselx/haddr/hwrite/htrans/hwdata/hready/hrdata) between numReq local requesters.
- Round-robin arbitration; one single-beat NONSEQ transfer outstanding at a time.
- Sequences each transfer through the AHB address phase and data phase.
- Returns read data and a one-cycle completion pulse to the winning requester.

---
 rtl/ahb_master_arbiter_if.sv | 33 +++
 rtl/ahb_master_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter_if.sv
// Bundles the requester-side handshake and the shared AHB-Lite slave port.
// The arbiter uses the master modport; the environment uses the slave modport.
interface ahb_master_arbiter_if #(
  parameter int numReq    = 2,
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
);
  logic [numReq-1:0]           req;
  logic [numReq*addrWidth-1:0] req_addr;
  logic [numReq-1:0]           req_write;
  logic [numReq*dataWidth-1:0] req_wdata;
  logic [numReq-1:0]           grant;
  logic [numReq-1:0]           done;
  logic [dataWidth-1:0]        rdata;
  logic                        busy;
  logic                        hselx;
  logic [addrWidth-1:0]        haddr;
  logic                        hwrite;
  logic [1:0]                  htrans;
  logic [dataWidth-1:0]        hwdata;
  logic                        hready;
  logic [dataWidth-1:0]        hrdata;

  modport master (
    input  req, req_addr, req_write, req_wdata, hready, hrdata,
    output grant, done, rdata, busy, hselx, haddr, hwrite, htrans, hwdata
  );

  modport slave (
    output req, req_addr, req_write, req_wdata, hready, hrdata,
    input  grant, done, rdata, busy, hselx, haddr, hwrite, htrans, hwdata
  );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite port among numReq requesters,
// running one single-beat NONSEQ transfer at a time through ADDR and DATA phases.
module ahb_master_arbiter #(
  parameter int numReq    = 2,
  parameter int addrWidth = 8,
  parameter int dataWidth = 32
) (
  input logic                 hclk_i,
  input logic                 hreset_i,
  ahb_master_arbiter_if.master bus
);

  localparam int idxW = (numReq > 1) ? $clog2(numReq) : 1;
  localparam logic [idxW-1:0] lastIdx  = idxW'(numReq - 1);
  localparam logic [idxW:0]   numReqW  = (idxW+1)'(numReq);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [idxW-1:0]        ptr_q, ptr_d;
  logic [idxW-1:0]        owner_q, owner_d;
  logic [addrWidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [dataWidth-1:0]   wdata_q, wdata_d;
  logic [numReq-1:0]      grant_q, grant_d;
  logic [numReq-1:0]      done_q, done_d;
  logic [dataWidth-1:0]   rdata_q, rdata_d;

  logic                   found;
  logic [idxW-1:0]        pick;
  logic [idxW:0]          candWide;
  logic [idxW-1:0]        cand;

  // Search starts one past the last owner so the previous winner ranks last.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    candWide = '0;
    cand     = '0;
    for (int i = 1; i <= numReq; i++) begin
      candWide = {1'b0, ptr_q} + (idxW+1)'(i);
      if (candWide >= numReqW) candWide = candWide - numReqW;
      cand = candWide[idxW-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      state_q <= IDLE;
      ptr_q   <= lastIdx;
      owner_q <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    done_d  = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d       = pick;
          addr_d        = bus.req_addr[pick*addrWidth +: addrWidth];
          write_d       = bus.req_write[pick];
          wdata_d       = bus.req_wdata[pick*dataWidth +: dataWidth];
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          state_d       = ADDR;
        end
      end
      ADDR: begin
        if (bus.hready) state_d = DATA;
      end
      DATA: begin
        if (bus.hready) begin
          if (!write_q) rdata_d = bus.hrdata;
          done_d  = grant_q;
          ptr_d   = owner_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode from state so an async reset idles them at once.
  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.hselx  = (state_q == ADDR);
  assign bus.htrans = (state_q == ADDR) ? 2'b10 : 2'b00;
  assign bus.haddr  = (state_q == ADDR) ? addr_q : '0;
  assign bus.hwrite = (state_q == ADDR) && write_q;
  assign bus.hwdata = ((state_q == DATA) && write_q) ? wdata_q : '0;

endmodule
